// File: rtl/qed_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : qed_pkg
//  Description : Shared constants, checker state encoding and the register
//                remapping used by the QED duplicate-instruction constraint.
//  Revision    : 1.0
// ============================================================================
package qed_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_ERROR = 2'd2
    } qed_state_t;

    // The duplicate copy uses the mirrored register bank: 1..12 <-> 12..1, 13..31 <-> 31..13
    function automatic logic [4:0] reg_map(input logic [4:0] rd);
        logic [5:0] w_tmp;
        if (rd == 5'd0) begin
            w_tmp = 6'd0;
        end else if (rd <= 5'd12) begin
            w_tmp = 6'd13 - {1'b0, rd};
        end else begin
            w_tmp = 6'd44 - {1'b0, rd};
        end
        return w_tmp[4:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/qed_wb_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : qed_wb_fifo
//  Description : Small power-of-two FIFO for writeback entries; a push into a
//                full FIFO is accepted only when a pop happens in that cycle.
//  Revision    : 1.0
// ============================================================================
module qed_wb_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 37
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_ptr_w:0] c_depth = DEPTH[c_ptr_w:0];

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wptr;
    logic [c_ptr_w-1:0] r_rptr;
    logic [c_ptr_w:0]   r_count;

    logic w_do_pop;
    logic w_do_push;

    assign full      = (r_count == c_depth);
    assign empty     = (r_count == '0);
    assign head      = r_mem[r_rptr];
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/qed_wb_checker.sv
`default_nettype none
// ============================================================================
//  Module      : qed_wb_checker
//  Description : Pairs register writebacks of two cores through per-core FIFOs
//                and flags the first pair that violates the QED register map.
//  Revision    : 1.0
// ============================================================================
module qed_wb_checker #(
    parameter int DEPTH = 4,
    parameter int XLEN  = qed_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            check_en,
    input  logic            cpu0_wb_valid,
    input  logic [4:0]      cpu0_wb_rd,
    input  logic [XLEN-1:0] cpu0_wb_data,
    input  logic            cpu1_wb_valid,
    input  logic [4:0]      cpu1_wb_rd,
    input  logic [XLEN-1:0] cpu1_wb_data,
    output logic            mismatch,
    output logic            overflow,
    output logic            qed_ready,
    output logic [15:0]     match_count,
    output logic [4:0]      err_rd,
    output logic [XLEN-1:0] err_data0,
    output logic [XLEN-1:0] err_data1
);

    import qed_pkg::*;

    localparam int c_ent_w = XLEN + 5;

    qed_state_t r_state;
    qed_state_t w_state_nxt;

    logic               w_run;
    logic               w_push0, w_push1, w_pop, w_flush;
    logic               w_full0, w_full1, w_empty0, w_empty1;
    logic [c_ent_w-1:0] w_head0, w_head1;
    logic               w_match, w_ovf;

    logic               r_mismatch;
    logic               r_overflow;
    logic [15:0]        r_match_count;
    logic [4:0]         r_err_rd;
    logic [XLEN-1:0]    r_err_data0;
    logic [XLEN-1:0]    r_err_data1;

    assign w_run   = (r_state == ST_RUN);
    assign w_flush = (r_state == ST_IDLE);
    assign w_push0 = w_run && cpu0_wb_valid && (cpu0_wb_rd != 5'd0);
    assign w_push1 = w_run && cpu1_wb_valid && (cpu1_wb_rd != 5'd0);
    assign w_pop   = w_run && !w_empty0 && !w_empty1;

    assign w_match = (reg_map(w_head0[c_ent_w-1 -: 5]) == w_head1[c_ent_w-1 -: 5]) &&
                     (w_head0[XLEN-1:0] == w_head1[XLEN-1:0]);

    // A full FIFO only drops when the shared pop does not free a slot this cycle
    assign w_ovf = (w_push0 && w_full0 && !w_pop) || (w_push1 && w_full1 && !w_pop);

    qed_wb_fifo #(.DEPTH(DEPTH), .WIDTH(c_ent_w)) u_fifo0 (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push0),
        .pop   (w_pop),
        .flush (w_flush),
        .din   ({cpu0_wb_rd, cpu0_wb_data}),
        .full  (w_full0),
        .empty (w_empty0),
        .head  (w_head0)
    );

    qed_wb_fifo #(.DEPTH(DEPTH), .WIDTH(c_ent_w)) u_fifo1 (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push1),
        .pop   (w_pop),
        .flush (w_flush),
        .din   ({cpu1_wb_rd, cpu1_wb_data}),
        .full  (w_full1),
        .empty (w_empty1),
        .head  (w_head1)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (check_en) w_state_nxt = ST_RUN;
            ST_RUN: begin
                if (r_mismatch) begin
                    w_state_nxt = ST_ERROR;
                end else if (!check_en) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ERROR: w_state_nxt = ST_ERROR;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mismatch    <= 1'b0;
            r_overflow    <= 1'b0;
            r_match_count <= '0;
            r_err_rd      <= '0;
            r_err_data0   <= '0;
            r_err_data1   <= '0;
        end else begin
            if (w_ovf) begin
                r_overflow <= 1'b1;
            end
            if (w_pop) begin
                if (w_match) begin
                    if (r_match_count != 16'hFFFF) begin
                        r_match_count <= r_match_count + 16'd1;
                    end
                end else begin
                    r_mismatch <= 1'b1;
                    // Only the first failing pair is kept for debug
                    if (!r_mismatch) begin
                        r_err_rd    <= w_head0[c_ent_w-1 -: 5];
                        r_err_data0 <= w_head0[XLEN-1:0];
                        r_err_data1 <= w_head1[XLEN-1:0];
                    end
                end
            end
        end
    end

    assign mismatch    = r_mismatch;
    assign overflow    = r_overflow;
    assign match_count = r_match_count;
    assign err_rd      = r_err_rd;
    assign err_data0   = r_err_data0;
    assign err_data1   = r_err_data1;
    assign qed_ready   = w_run && w_empty0 && w_empty1 && !r_mismatch &&
                         !r_overflow && (r_match_count != 16'd0);

endmodule
`default_nettype wire
